// File: rtl/seven_segment_mux_counter.sv
`default_nettype none
// ============================================================================
// Module  : seven_segment_mux_counter
// Brief   : Prescaled up/down BCD counter, multiplexed onto one 7-seg bus
// Revision: 1.0
// ============================================================================
module seven_segment_mux_counter #(
    parameter int DIGITS    = 4,
    parameter int CMP_W     = 24,
    parameter int CMP_RESET = 100,
    parameter int SCAN_W    = 10
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,
    input  logic                  en_i,
    input  logic                  up_i,
    input  logic                  clear_i,
    input  logic                  lzb_i,
    input  logic                  update_compare_i,
    input  logic [CMP_W-1:0]      compare_i,
    output logic [6:0]            seg_o,
    output logic [DIGITS-1:0]     dig_o,
    output logic [4*DIGITS-1:0]   value_o,
    output logic                  wrap_o
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [IDX_W-1:0]  c_IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [IDX_W-1:0]  c_IDX_ONE   = IDX_W'(1);
    localparam logic [CMP_W-1:0]  c_CMP_ONE   = CMP_W'(1);
    // A zero period would underflow the terminal-count compare, so clamp to 1.
    localparam logic [CMP_W-1:0]  c_CMP_RESET = (CMP_RESET == 0) ? c_CMP_ONE : CMP_W'(CMP_RESET);
    localparam logic [SCAN_W-1:0] c_SCAN_ONE  = SCAN_W'(1);
    localparam logic [DIGITS-1:0] c_DIG_ONE   = DIGITS'(1);

    logic [CMP_W-1:0]    r_cmp;
    logic [CMP_W-1:0]    r_pre;
    logic [4*DIGITS-1:0] r_cnt;
    logic                r_wrap;
    logic [SCAN_W-1:0]   r_scan;
    logic [IDX_W-1:0]    r_idx;
    logic [DIGITS-1:0]   r_dig;
    logic [6:0]          r_seg;

    logic                w_pre_hit;
    logic                w_tick;
    logic [4*DIGITS-1:0] w_next;
    logic                w_carry;
    logic [3:0]          w_digit [DIGITS];
    logic [DIGITS-1:0]   w_lead;
    logic                w_any;
    logic [3:0]          w_sel;
    logic                w_blank;
    logic [DIGITS-1:0]   w_onehot;

    function automatic logic [6:0] f_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // >= rather than == so a freshly lowered period takes effect at once.
    assign w_pre_hit = (r_pre >= (r_cmp - c_CMP_ONE));
    assign w_tick    = en_i & w_pre_hit & ~clear_i & ~update_compare_i;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_cmp <= c_CMP_RESET;
        end else if (update_compare_i) begin
            r_cmp <= (compare_i == '0) ? c_CMP_ONE : compare_i;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_pre <= '0;
        end else if (clear_i || update_compare_i) begin
            r_pre <= '0;
        end else if (en_i) begin
            r_pre <= w_pre_hit ? '0 : (r_pre + c_CMP_ONE);
        end
    end

    // Ripple carry/borrow across digits; a carry out of the top digit is a wrap.
    always_comb begin
        w_next  = r_cnt;
        w_carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_carry) begin
                if (up_i) begin
                    if (r_cnt[4*i +: 4] == 4'd9) begin
                        w_next[4*i +: 4] = 4'd0;
                    end else begin
                        w_next[4*i +: 4] = r_cnt[4*i +: 4] + 4'd1;
                        w_carry          = 1'b0;
                    end
                end else begin
                    if (r_cnt[4*i +: 4] == 4'd0) begin
                        w_next[4*i +: 4] = 4'd9;
                    end else begin
                        w_next[4*i +: 4] = r_cnt[4*i +: 4] - 4'd1;
                        w_carry          = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (clear_i) begin
                r_cnt <= '0;
            end else if (w_tick) begin
                r_cnt  <= w_next;
                r_wrap <= w_carry;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_scan <= '0;
            r_idx  <= '0;
        end else begin
            r_scan <= r_scan + c_SCAN_ONE;
            if (&r_scan) begin
                r_idx <= (r_idx == c_IDX_LAST) ? '0 : (r_idx + c_IDX_ONE);
            end
        end
    end

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_unpack
        assign w_digit[gi] = r_cnt[4*gi +: 4];
    end

    // w_lead[i] is set when digit i and every digit above it are zero.
    always_comb begin
        w_lead = '0;
        w_any  = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_any     = w_any | (w_digit[i] != 4'd0);
            w_lead[i] = ~w_any;
        end
    end

    assign w_sel    = w_digit[r_idx];
    assign w_blank  = lzb_i & (r_idx != '0) & w_lead[r_idx];
    assign w_onehot = c_DIG_ONE << r_idx;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_dig <= c_DIG_ONE;
            r_seg <= 7'h3F;
        end else begin
            r_dig <= w_onehot;
            r_seg <= w_blank ? 7'h00 : f_decode(w_sel);
        end
    end

    assign seg_o   = r_seg;
    assign dig_o   = r_dig;
    assign value_o = r_cnt;
    assign wrap_o  = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_mux_counter.sv
`default_nettype none
// ============================================================================
// Module  : tb_seven_segment_mux_counter
// Brief   : Scoreboard bench: value/wrap events and display scan events
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_seven_segment_mux_counter;

    localparam int DIGITS    = 4;
    localparam int CMP_W     = 8;
    localparam int CMP_RESET = 3;
    localparam int SCAN_W    = 2;

    logic             clk     = 1'b0;
    logic             rst_n   = 1'b0;
    logic             en      = 1'b0;
    logic             up      = 1'b1;
    logic             clr     = 1'b0;
    logic             lzb     = 1'b0;
    logic             upd     = 1'b0;
    logic [CMP_W-1:0] cmpv    = '0;
    logic [6:0]       seg_o;
    logic [3:0]       dig_o;
    logic [15:0]      value_o;
    logic             wrap_o;

    seven_segment_mux_counter #(
        .DIGITS   (DIGITS),
        .CMP_W    (CMP_W),
        .CMP_RESET(CMP_RESET),
        .SCAN_W   (SCAN_W)
    ) u_dut (
        .wb_clk_i        (clk),
        .wb_rst_ni       (rst_n),
        .en_i            (en),
        .up_i            (up),
        .clear_i         (clr),
        .lzb_i           (lzb),
        .update_compare_i(upd),
        .compare_i       (cmpv),
        .seg_o           (seg_o),
        .dig_o           (dig_o),
        .value_o         (value_o),
        .wrap_o          (wrap_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [15:0] v; logic w; int c; } vexp_t;
    typedef struct { logic [3:0] d; logic [6:0] s; } dexp_t;
    vexp_t vq[$];
    dexp_t dq[$];
    logic  disp_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_v(input logic [15:0] v, input logic w, input int c);
        vexp_t e;
        e.v = v; e.w = w; e.c = c;
        vq.push_back(e);
    endtask

    task automatic push_d(input logic [3:0] d, input logic [6:0] s);
        dexp_t e;
        e.d = d; e.s = s;
        dq.push_back(e);
    endtask

    function automatic logic [15:0] bcd(input int n);
        logic [15:0] r;
        r = {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
        return r;
    endfunction

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Land on the second negedge of a fresh dig_o == 8 window.
    task automatic sync_dig8();
        int n;
        n = 0;
        while (dig_o == 4'd8 && n < 64) begin @(negedge clk); n++; end
        while (dig_o != 4'd8 && n < 64) begin @(negedge clk); n++; end
        if (n >= 64) chk("dig_sync_timeout", 32'(dig_o), 32'd8);
        @(negedge clk);
    endtask

    // Value/wrap monitor: every change of value_o consumes one expected event.
    logic [15:0] prev_val = '0;
    vexp_t       ve;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_val = value_o;
        end else if (value_o !== prev_val) begin
            if (vq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_value_change: got %0h, none expected (cycle %0d)", value_o, cyc);
            end else begin
                ve = vq.pop_front();
                chk("value", 32'(value_o), 32'(ve.v));
                chk("wrap_on_change", 32'(wrap_o), 32'(ve.w));
                chk("change_cycle", 32'(cyc), 32'(ve.c));
            end
            prev_val = value_o;
        end else begin
            chk("wrap_idle", 32'(wrap_o), 32'd0);
        end
    end

    // Display monitor: each dig_o change consumes one expected {dig, seg} pair.
    logic [3:0] prev_dig = 4'd1;
    int         last_chg = 0;
    dexp_t      de;
    always @(negedge clk) begin
        if (dig_o !== prev_dig) begin
            if (disp_on) begin
                if (dq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_dig_change: got %0h, none expected (cycle %0d)", dig_o, cyc);
                end else begin
                    de = dq.pop_front();
                    chk("dig", 32'(dig_o), 32'(de.d));
                    chk("seg", 32'(seg_o), 32'(de.s));
                end
                if (last_chg > 0) chk("dig_hold_cycles", 32'(cyc - last_chg), 32'd4);
            end
            last_chg = cyc;
            prev_dig = dig_o;
        end
    end

    initial begin
        int c0, b, d, r;
        repeat (3) @(negedge clk);
        chk("reset_value", 32'(value_o), 32'h0);
        chk("reset_wrap", 32'(wrap_o), 32'h0);
        chk("reset_dig", 32'(dig_o), 32'h1);
        chk("reset_seg", 32'(seg_o), 32'h3F);

        // Up-count at the reset period of 3, clear collision at 0x0042,
        // then a zero compare load on a tick cycle and one tick per clock.
        c0 = cyc;
        for (int k = 1; k <= 42; k++) push_v(bcd(k), 1'b0, c0 + 3 * k);
        push_v(16'h0000, 1'b0, c0 + 129);
        push_v(16'h0001, 1'b0, c0 + 132);
        for (int v = 2; v <= 305; v++) push_v(bcd(v), 1'b0, c0 + 134 + v);
        rst_n = 1'b1; en = 1'b1; up = 1'b1;
        wait_to(c0 + 128); clr = 1'b1;
        @(negedge clk);    clr = 1'b0;
        wait_to(c0 + 134); upd = 1'b1; cmpv = '0;
        @(negedge clk);    upd = 1'b0;
        wait_to(c0 + 439); en = 1'b0;

        // Scan with blanking on, then off, while the count holds 0x0305.
        lzb = 1'b1;
        sync_dig8();
        push_d(4'd1, 7'h6D); push_d(4'd2, 7'h3F); push_d(4'd4, 7'h4F); push_d(4'd8, 7'h00);
        disp_on = 1'b1;
        repeat (16) @(negedge clk);
        disp_on = 1'b0;
        chk("disp_lzb_on_drained", 32'(dq.size()), 32'd0);
        lzb = 1'b0;
        sync_dig8();
        push_d(4'd1, 7'h6D); push_d(4'd2, 7'h3F); push_d(4'd4, 7'h4F); push_d(4'd8, 7'h3F);
        disp_on = 1'b1;
        repeat (16) @(negedge clk);
        disp_on = 1'b0;
        chk("disp_lzb_off_drained", 32'(dq.size()), 32'd0);

        // Period 5 with a 7-cycle enable gap in mid-period.
        b = cyc;
        push_v(16'h0306, 1'b0, b + 6);
        push_v(16'h0307, 1'b0, b + 18);
        upd = 1'b1; cmpv = 8'd5; en = 1'b1;
        @(negedge clk);  upd = 1'b0;
        wait_to(b + 7);  en = 1'b0;
        wait_to(b + 14); en = 1'b1;
        wait_to(b + 18); en = 1'b0;

        // Clear, then down through 0000 -> 9999, then up through 9999 -> 0000.
        d = cyc;
        push_v(16'h0000, 1'b0, d + 1);
        push_v(16'h9999, 1'b1, d + 3);
        push_v(16'h9998, 1'b0, d + 4);
        push_v(16'h9997, 1'b0, d + 5);
        push_v(16'h9998, 1'b0, d + 6);
        push_v(16'h9999, 1'b0, d + 7);
        push_v(16'h0000, 1'b1, d + 8);
        push_v(16'h0001, 1'b0, d + 9);
        push_v(16'h0002, 1'b0, d + 10);
        push_v(16'h0003, 1'b0, d + 11);
        clr = 1'b1;
        @(negedge clk); clr = 1'b0; upd = 1'b1; cmpv = 8'd1; up = 1'b0; en = 1'b1;
        @(negedge clk); upd = 1'b0;
        wait_to(d + 5); up = 1'b1;
        wait_to(d + 11);

        // Asynchronous reset between edges, mid-count.
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_value", 32'(value_o), 32'h0);
        chk("async_rst_wrap", 32'(wrap_o), 32'h0);
        chk("async_rst_dig", 32'(dig_o), 32'h1);
        chk("async_rst_seg", 32'(seg_o), 32'h3F);
        repeat (2) @(negedge clk);
        r = cyc;
        push_v(16'h0001, 1'b0, r + CMP_RESET);
        rst_n = 1'b1; en = 1'b1; up = 1'b1;
        wait_to(r + CMP_RESET + 2);
        chk("value_events_drained", 32'(vq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
